// File: rtl/ysyx_24100029_arb_pkg.sv
// Shared state encoding, grant codes and helpers for the core-side AXI read arbiter.
package ysyx_24100029_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;
  localparam logic [1:0] GNT_NONE = 2'b00;

  // last_win holds the index of the previous winner, so bit 1 of a grant doubles as its value.
  localparam logic LAST_IFU = 1'b0;
  localparam logic LAST_LSU = 1'b1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/ysyx_24100029_axi_rd_arbiter_if.sv
// AXI4 bus bundle (all five channels) with master- and slave-side views.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/ysyx_24100029_rr_pick.sv
// Combinational two-way winner selection: round-robin, or LSU-first with an IFU override.
module ysyx_24100029_rr_pick
  import ysyx_24100029_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_win,
  input  logic       force_ifu,
  input  logic       fixed_mode,
  output logic [1:0] win
);

  always_comb begin
    win = GNT_NONE;
    case (req)
      2'b01: win = GNT_IFU;
      2'b10: win = GNT_LSU;
      2'b11: begin
        if (fixed_mode) begin
          win = force_ifu ? GNT_IFU : GNT_LSU;
        end else begin
          // Contested round-robin: whoever did not win last time goes now.
          win = (last_win == LAST_LSU) ? GNT_IFU : GNT_LSU;
        end
      end
      default: win = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ysyx_24100029_axi_rd_arbiter.sv
// Shares the core's single AXI4 read port between IFU and LSU, one read outstanding at a time;
// LSU writes bypass the arbiter entirely.
module ysyx_24100029_axi_rd_arbiter
  import ysyx_24100029_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit LSU_FIXED  = 1'b0,
  parameter int MAX_WAIT   = 15
) (
  input  logic       clock,
  input  logic       reset,
  axi4_if.slave      ifu_axi,
  axi4_if.slave      lsu_axi,
  axi4_if.master     mem_axi,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  arb_state_t      state_reg, state_next;
  logic [1:0]      grant_reg, grant_next;
  logic            last_win_reg, last_win_next;
  logic [3:0]      wait_cnt_reg, wait_cnt_next;

  logic [1:0]      req;
  logic [1:0]      win;
  logic            force_ifu;
  logic            in_addr;
  logic            in_data;
  logic            sel_lsu;
  logic            mem_rready;
  logic [1:0]      m_rready;
  logic [1:0]      m_arready;
  logic [1:0]      m_rvalid;
  logic [ADDR_WIDTH-1:0] ar_addr_sel;

  assign req       = {lsu_axi.arvalid, ifu_axi.arvalid};
  assign force_ifu = LSU_FIXED && (wait_cnt_reg == MAX_WAIT_L);
  assign in_addr   = (state_reg == ADDR);
  assign in_data   = (state_reg == DATA);
  assign sel_lsu   = grant_reg[1];

  ysyx_24100029_rr_pick u_pick (
    .req        (req),
    .last_win   (last_win_reg),
    .force_ifu  (force_ifu),
    .fixed_mode (LSU_FIXED),
    .win        (win)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= GNT_NONE;
      last_win_reg <= LAST_LSU;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_win_reg <= last_win_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_win_next = last_win_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (win != GNT_NONE) begin
          state_next    = ADDR;
          grant_next    = win;
          last_win_next = win[1];
          if (LSU_FIXED) begin
            if (win == GNT_IFU) begin
              wait_cnt_next = 4'd0;
            end else if (req[0]) begin
              wait_cnt_next = sat_inc4(wait_cnt_reg);
            end
          end
        end
      end
      ADDR: begin
        if (mem_axi.arready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        // Error responses do not terminate a burst; only the last beat does.
        if (mem_axi.rvalid && mem_rready && mem_axi.rlast) begin
          state_next = IDLE;
          grant_next = GNT_NONE;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = GNT_NONE;
      end
    endcase
  end

  // AR request steering: the granted master's fields drive the slave while in ADDR.
  assign ar_addr_sel     = sel_lsu ? lsu_axi.araddr : ifu_axi.araddr;
  assign mem_axi.araddr  = ar_addr_sel;
  assign mem_axi.arid    = sel_lsu ? lsu_axi.arid    : ifu_axi.arid;
  assign mem_axi.arlen   = sel_lsu ? lsu_axi.arlen   : ifu_axi.arlen;
  assign mem_axi.arsize  = sel_lsu ? lsu_axi.arsize  : ifu_axi.arsize;
  assign mem_axi.arburst = sel_lsu ? lsu_axi.arburst : ifu_axi.arburst;
  assign mem_axi.arvalid = in_addr;

  // Per-master handshake gating: only the granted master ever sees arready or rvalid.
  assign m_rready = {lsu_axi.rready, ifu_axi.rready};
  for (genvar gi = 0; gi < 2; gi++) begin : g_hs
    assign m_arready[gi] = in_addr & grant_reg[gi] & mem_axi.arready;
    assign m_rvalid[gi]  = in_data & grant_reg[gi] & mem_axi.rvalid;
  end

  assign ifu_axi.arready = m_arready[0];
  assign lsu_axi.arready = m_arready[1];
  assign ifu_axi.rvalid  = m_rvalid[0];
  assign lsu_axi.rvalid  = m_rvalid[1];

  // Stray beats outside DATA are left unaccepted rather than routed anywhere.
  assign mem_rready     = in_data & (|(grant_reg & m_rready));
  assign mem_axi.rready = mem_rready;

  assign ifu_axi.rid   = mem_axi.rid;
  assign ifu_axi.rdata = mem_axi.rdata;
  assign ifu_axi.rresp = mem_axi.rresp;
  assign ifu_axi.rlast = mem_axi.rlast;
  assign lsu_axi.rid   = mem_axi.rid;
  assign lsu_axi.rdata = mem_axi.rdata;
  assign lsu_axi.rresp = mem_axi.rresp;
  assign lsu_axi.rlast = mem_axi.rlast;

  // LSU write channels are straight wires to the slave.
  assign mem_axi.awid    = lsu_axi.awid;
  assign mem_axi.awaddr  = lsu_axi.awaddr;
  assign mem_axi.awlen   = lsu_axi.awlen;
  assign mem_axi.awsize  = lsu_axi.awsize;
  assign mem_axi.awburst = lsu_axi.awburst;
  assign mem_axi.awvalid = lsu_axi.awvalid;
  assign lsu_axi.awready = mem_axi.awready;
  assign mem_axi.wdata   = lsu_axi.wdata;
  assign mem_axi.wstrb   = lsu_axi.wstrb;
  assign mem_axi.wlast   = lsu_axi.wlast;
  assign mem_axi.wvalid  = lsu_axi.wvalid;
  assign lsu_axi.wready  = mem_axi.wready;
  assign lsu_axi.bid     = mem_axi.bid;
  assign lsu_axi.bresp   = mem_axi.bresp;
  assign lsu_axi.bvalid  = mem_axi.bvalid;
  assign mem_axi.bready  = lsu_axi.bready;

  // The IFU never writes.
  assign ifu_axi.awready = 1'b0;
  assign ifu_axi.wready  = 1'b0;
  assign ifu_axi.bvalid  = 1'b0;
  assign ifu_axi.bid     = '0;
  assign ifu_axi.bresp   = 2'b00;

  assign grant = grant_reg;
  assign busy  = (state_reg != IDLE);

endmodule
